// File: rtl/seg14_pkg.sv
// seg14_pkg
// Shared definitions for the 14-segment display capture path.
//   - character codes produced by the glyph decoder (0..9, A..Z, N-tilde,
//     space, and the "unknown glyph" marker)
//   - 14-bit glyph patterns, bit 13 = segment a down to bit 0 = segment m,
//     in the order a b c d e f g1 g2 h i j k l m
//   - capture state machine encoding
package seg14_pkg;

    localparam int NUM_DIGITS  = 12;
    localparam int FRAME_CNT_W = 8;

    localparam logic [5:0] CH_0 = 6'd0;
    localparam logic [5:0] CH_1 = 6'd1;
    localparam logic [5:0] CH_2 = 6'd2;
    localparam logic [5:0] CH_3 = 6'd3;
    localparam logic [5:0] CH_4 = 6'd4;
    localparam logic [5:0] CH_5 = 6'd5;
    localparam logic [5:0] CH_6 = 6'd6;
    localparam logic [5:0] CH_7 = 6'd7;
    localparam logic [5:0] CH_8 = 6'd8;
    localparam logic [5:0] CH_9 = 6'd9;
    localparam logic [5:0] CH_A = 6'd10;
    localparam logic [5:0] CH_B = 6'd11;
    localparam logic [5:0] CH_C = 6'd12;
    localparam logic [5:0] CH_D = 6'd13;
    localparam logic [5:0] CH_E = 6'd14;
    localparam logic [5:0] CH_F = 6'd15;
    localparam logic [5:0] CH_G = 6'd16;
    localparam logic [5:0] CH_H = 6'd17;
    localparam logic [5:0] CH_I = 6'd18;
    localparam logic [5:0] CH_J = 6'd19;
    localparam logic [5:0] CH_K = 6'd20;
    localparam logic [5:0] CH_L = 6'd21;
    localparam logic [5:0] CH_M = 6'd22;
    localparam logic [5:0] CH_N = 6'd23;
    localparam logic [5:0] CH_O = 6'd24;
    localparam logic [5:0] CH_P = 6'd25;
    localparam logic [5:0] CH_Q = 6'd26;
    localparam logic [5:0] CH_R = 6'd27;
    localparam logic [5:0] CH_S = 6'd28;
    localparam logic [5:0] CH_T = 6'd29;
    localparam logic [5:0] CH_U = 6'd30;
    localparam logic [5:0] CH_V = 6'd31;
    localparam logic [5:0] CH_W = 6'd32;
    localparam logic [5:0] CH_X = 6'd33;
    localparam logic [5:0] CH_Y = 6'd34;
    localparam logic [5:0] CH_Z = 6'd35;
    localparam logic [5:0] CH_NN    = 6'd36;
    localparam logic [5:0] CH_SPACE = 6'd37;
    localparam logic [5:0] CH_BAD   = 6'd63;

    // Zero carries a slash (j + m) so it stays distinct from the letter O.
    localparam logic [13:0] GL_0 = 14'b11111100001001;
    localparam logic [13:0] GL_1 = 14'b01100000000000;
    localparam logic [13:0] GL_2 = 14'b11011011000000;
    localparam logic [13:0] GL_3 = 14'b11110011000000;
    localparam logic [13:0] GL_4 = 14'b01100111000000;
    localparam logic [13:0] GL_5 = 14'b10110111000000;  // same pattern as S
    localparam logic [13:0] GL_6 = 14'b10111111000000;
    localparam logic [13:0] GL_7 = 14'b11100000000000;
    localparam logic [13:0] GL_8 = 14'b11111111000000;
    localparam logic [13:0] GL_9 = 14'b11110111000000;
    localparam logic [13:0] GL_A = 14'b11101111000000;
    localparam logic [13:0] GL_B = 14'b11110001010010;
    localparam logic [13:0] GL_C = 14'b10011100000000;
    localparam logic [13:0] GL_D = 14'b11110000010010;
    localparam logic [13:0] GL_E = 14'b10011110000000;
    localparam logic [13:0] GL_F = 14'b10001110000000;
    localparam logic [13:0] GL_G = 14'b10111101000000;
    localparam logic [13:0] GL_H = 14'b01101111000000;
    localparam logic [13:0] GL_I = 14'b10010000010010;
    localparam logic [13:0] GL_J = 14'b01111000000000;
    localparam logic [13:0] GL_K = 14'b00001110001100;
    localparam logic [13:0] GL_L = 14'b00011100000000;
    localparam logic [13:0] GL_M = 14'b01101100101000;
    localparam logic [13:0] GL_N = 14'b01101100100001;
    localparam logic [13:0] GL_O = 14'b11111100000000;
    localparam logic [13:0] GL_P = 14'b11001111000000;
    localparam logic [13:0] GL_Q = 14'b11111100000001;
    localparam logic [13:0] GL_R = 14'b11001111000001;
    localparam logic [13:0] GL_S = 14'b10110111000000;
    localparam logic [13:0] GL_T = 14'b10000000010010;
    localparam logic [13:0] GL_U = 14'b01111100000000;
    localparam logic [13:0] GL_V = 14'b00001100001100;
    localparam logic [13:0] GL_W = 14'b01101100000101;
    localparam logic [13:0] GL_X = 14'b00000000101101;
    localparam logic [13:0] GL_Y = 14'b00000000101010;
    localparam logic [13:0] GL_Z = 14'b10010000001100;
    localparam logic [13:0] GL_NN    = 14'b11101100100001;
    localparam logic [13:0] GL_SPACE = 14'b00000000000000;

    typedef enum logic {
        HUNT = 1'b0,
        CAPT = 1'b1
    } state_t;

endpackage

// File: rtl/seg14_scan_decoder_if.sv
// seg14_scan_decoder_if
// Bundle between the display snoop point / reader and the scan decoder.
//   sel, segm    : snooped digit select (one-hot) and segment pattern
//   rd_addr      : frame-buffer read address
//   rd_data      : registered character code at rd_addr
//   frame_valid, frame_done, seq_err, glyph_err, frame_cnt : frame status
//   state        : capture FSM state, exposed for observation
// There is no valid/ready pair: sel/segm are sampled on every rising edge
// (sel == 0 acts as "not valid") and the decoder never back-pressures; the
// read port always answers one cycle after rd_addr is presented.
interface seg14_scan_decoder_if #(
    parameter int CNT_W = 8
);
    import seg14_pkg::*;

    logic [11:0]      sel;
    logic [13:0]      segm;
    logic [3:0]       rd_addr;
    logic [5:0]       rd_data;
    logic             frame_valid;
    logic             frame_done;
    logic             seq_err;
    logic             glyph_err;
    logic [CNT_W-1:0] frame_cnt;
    state_t           state;

    modport master (
        output sel, segm, rd_addr,
        input  rd_data, frame_valid, frame_done, seq_err, glyph_err,
               frame_cnt, state
    );

    modport slave (
        input  sel, segm, rd_addr,
        output rd_data, frame_valid, frame_done, seq_err, glyph_err,
               frame_cnt, state
    );

endinterface

// File: rtl/seg14_glyph_decode.sv
// seg14_glyph_decode
// Combinational 14-segment pattern to 6-bit character code lookup.
//   segm : segment pattern, bit 13 = segment a
//   code : character code, CH_BAD for any pattern not in the table
module seg14_glyph_decode
    import seg14_pkg::*;
(
    input  logic [13:0] segm,
    output logic [5:0]  code
);

    always_comb begin
        code = CH_BAD;
        case (segm)
            GL_0:     code = CH_0;
            GL_1:     code = CH_1;
            GL_2:     code = CH_2;
            GL_3:     code = CH_3;
            GL_4:     code = CH_4;
            // GL_5 has no entry: it is the S pattern and decodes to S.
            GL_6:     code = CH_6;
            GL_7:     code = CH_7;
            GL_8:     code = CH_8;
            GL_9:     code = CH_9;
            GL_A:     code = CH_A;
            GL_B:     code = CH_B;
            GL_C:     code = CH_C;
            GL_D:     code = CH_D;
            GL_E:     code = CH_E;
            GL_F:     code = CH_F;
            GL_G:     code = CH_G;
            GL_H:     code = CH_H;
            GL_I:     code = CH_I;
            GL_J:     code = CH_J;
            GL_K:     code = CH_K;
            GL_L:     code = CH_L;
            GL_M:     code = CH_M;
            GL_N:     code = CH_N;
            GL_O:     code = CH_O;
            GL_P:     code = CH_P;
            GL_Q:     code = CH_Q;
            GL_R:     code = CH_R;
            GL_S:     code = CH_S;
            GL_T:     code = CH_T;
            GL_U:     code = CH_U;
            GL_V:     code = CH_V;
            GL_W:     code = CH_W;
            GL_X:     code = CH_X;
            GL_Y:     code = CH_Y;
            GL_Z:     code = CH_Z;
            GL_NN:    code = CH_NN;
            GL_SPACE: code = CH_SPACE;
            default:  code = CH_BAD;
        endcase
    end

endmodule

// File: rtl/seg14_scan_decoder.sv
// seg14_scan_decoder
// Snoops a 12-digit multiplexed 14-segment display, decodes each glyph and
// assembles complete frames (digit 0 through 11 in order) into a shadow
// buffer. A completed frame is copied to the output buffer, which is read
// through a registered port.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of seg14_scan_decoder_if (snoop inputs, read port,
//              frame status, FSM state)
module seg14_scan_decoder
    import seg14_pkg::*;
#(
    parameter int N_DIGITS = NUM_DIGITS,
    parameter int CNT_W    = FRAME_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    seg14_scan_decoder_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(N_DIGITS - 1);

    logic [5:0]       code;
    logic             code_bad;
    logic             any_sel;
    logic             one_hot;
    logic             multi_hot;
    logic [3:0]       idx;

    state_t           state, state_nxt;
    logic [3:0]       exp_idx, exp_nxt;
    logic             gerr_acc, gerr_nxt;
    logic             sh_we;
    logic             commit;
    logic             seq_err_nxt;

    logic [5:0]       shadow [N_DIGITS];
    logic [5:0]       outbuf [N_DIGITS];
    logic [5:0]       rd_data_q;
    logic             frame_valid_q;
    logic             frame_done_q;
    logic             seq_err_q;
    logic             glyph_err_q;
    logic [CNT_W-1:0] cnt_q;

    seg14_glyph_decode u_glyph_decode (
        .segm (bus.segm),
        .code (code)
    );

    assign code_bad  = (code == CH_BAD);
    assign any_sel   = |bus.sel;
    assign one_hot   = any_sel && ((bus.sel & (bus.sel - 12'd1)) == 12'd0);
    assign multi_hot = any_sel && !one_hot;

    // OR-encode the select; only meaningful when one_hot is set.
    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (bus.sel[i]) begin
                idx = idx | 4'(i);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        exp_nxt     = exp_idx;
        gerr_nxt    = gerr_acc;
        sh_we       = 1'b0;
        commit      = 1'b0;
        seq_err_nxt = 1'b0;
        case (state)
            HUNT: begin
                if (multi_hot) begin
                    seq_err_nxt = 1'b1;
                end else if (one_hot && idx == 4'd0) begin
                    sh_we     = 1'b1;
                    gerr_nxt  = code_bad;
                    exp_nxt   = 4'd1;
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                if (multi_hot) begin
                    seq_err_nxt = 1'b1;
                    state_nxt   = HUNT;
                end else if (one_hot) begin
                    if (idx == exp_idx) begin
                        sh_we    = 1'b1;
                        gerr_nxt = gerr_acc | code_bad;
                        if (idx == LAST_IDX) begin
                            commit    = 1'b1;
                            state_nxt = HUNT;
                        end else begin
                            exp_nxt = exp_idx + 4'd1;
                        end
                    end else if (idx == exp_idx - 4'd1) begin
                        // Dwell on the digit just captured: refresh it.
                        sh_we    = 1'b1;
                        gerr_nxt = gerr_acc | code_bad;
                    end else begin
                        seq_err_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= HUNT;
            exp_idx       <= 4'd0;
            gerr_acc      <= 1'b0;
            rd_data_q     <= 6'd0;
            frame_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            seq_err_q     <= 1'b0;
            glyph_err_q   <= 1'b0;
            cnt_q         <= '0;
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow[i] <= CH_SPACE;
                outbuf[i] <= CH_SPACE;
            end
        end else begin
            state        <= state_nxt;
            exp_idx      <= exp_nxt;
            gerr_acc     <= gerr_nxt;
            frame_done_q <= commit;
            seq_err_q    <= seq_err_nxt;
            if (sh_we) begin
                shadow[idx] <= code;
            end
            if (commit) begin
                // Last digit bypasses the shadow so the frame lands in one edge.
                for (int i = 0; i < N_DIGITS; i++) begin
                    outbuf[i] <= (i == N_DIGITS - 1) ? code : shadow[i];
                end
                frame_valid_q <= 1'b1;
                glyph_err_q   <= gerr_nxt;
                cnt_q         <= cnt_q + 1'b1;
            end
            rd_data_q <= (bus.rd_addr <= LAST_IDX) ? outbuf[bus.rd_addr] : CH_SPACE;
        end
    end

    assign bus.rd_data     = rd_data_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.glyph_err   = glyph_err_q;
    assign bus.frame_cnt   = cnt_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// tb_seg14_scan_decoder
// Directed bench for seg14_scan_decoder: frame capture, dwell/blanking,
// sequence errors, unknown glyphs, reset mid-frame and counter wrap.
module tb_seg14_scan_decoder;
    import seg14_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg14_scan_decoder_if #(.CNT_W(8)) bus ();

    seg14_scan_decoder #(.N_DIGITS(12), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int serr_seen = 0;
    int base_done;
    int base_serr;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.frame_done) done_seen++;
        if (bus.seq_err) serr_seen++;
    end

    // Word 0: "GALLEGOS0000"; word 1: 5 O 0 N~ space Z 9 K X 1 W Q
    logic [13:0] word_pat  [2][12];
    logic [5:0]  word_code [2][12];

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [11:0] s, input logic [13:0] p);
        bus.sel  = s;
        bus.segm = p;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        bus.sel  = 12'd0;
        bus.segm = 14'd0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // hold > 1 repeats each digit and inserts one blanking cycle after it.
    task automatic sweep(input int w, input int hold, input int bad_digit);
        for (int d = 0; d < 12; d++) begin
            for (int h = 0; h < hold; h++) begin
                drive(12'd1 << d, (d == bad_digit) ? 14'b00000000000001 : word_pat[w][d]);
            end
            if (hold > 1) drive(12'd0, 14'h3fff);
        end
    endtask

    task automatic drive_partial(input int first, input int last);
        for (int d = first; d <= last; d++) begin
            drive(12'd1 << d, word_pat[0][d]);
        end
    endtask

    // blank != 0 expects the reset content (space) everywhere.
    task automatic check_frame(input string tag, input int w, input int bad_digit, input int blank);
        logic [5:0] exp_c;
        for (int a = 0; a < 12; a++) begin
            bus.sel     = 12'd0;
            bus.rd_addr = 4'(a);
            @(posedge clk);
            #1;
            if (blank != 0) exp_c = 6'd37;
            else if (a == bad_digit) exp_c = 6'd63;
            else exp_c = word_code[w][a];
            check($sformatf("%s_rd%0d", tag, a), 32'(bus.rd_data), 32'(exp_c));
        end
    endtask

    task automatic read_addr(input logic [3:0] a, input string tag, input logic [5:0] exp_c);
        bus.sel     = 12'd0;
        bus.rd_addr = a;
        @(posedge clk);
        #1;
        check(tag, 32'(bus.rd_data), 32'(exp_c));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        word_pat[0] = '{GL_G, GL_A, GL_L, GL_L, GL_E, GL_G, GL_O, GL_S, GL_0, GL_0, GL_0, GL_0};
        word_code[0] = '{6'd16, 6'd10, 6'd21, 6'd21, 6'd14, 6'd16, 6'd24, 6'd28,
                         6'd0, 6'd0, 6'd0, 6'd0};
        word_pat[1] = '{GL_5, GL_O, GL_0, GL_NN, GL_SPACE, GL_Z, GL_9, GL_K, GL_X, GL_1, GL_W, GL_Q};
        word_code[1] = '{6'd28, 6'd24, 6'd0, 6'd36, 6'd37, 6'd35, 6'd9, 6'd20,
                         6'd33, 6'd1, 6'd32, 6'd26};

        rst = 1'b1;
        bus.sel = 12'd0;
        bus.segm = 14'd0;
        bus.rd_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_data", 32'(bus.rd_data), 0);
        check("rst_frame_valid", 32'(bus.frame_valid), 0);
        check("rst_frame_done", 32'(bus.frame_done), 0);
        check("rst_seq_err", 32'(bus.seq_err), 0);
        check("rst_glyph_err", 32'(bus.glyph_err), 0);
        check("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        check("rst_state", 32'(bus.state), 32'(HUNT));
        rst = 1'b0;
        read_addr(4'd4, "rst_buf4", 6'd37);
        read_addr(4'd15, "rst_buf15", 6'd37);

        // Clean one-cycle-per-digit sweep.
        base_done = done_seen;
        base_serr = serr_seen;
        sweep(0, 1, -1);
        check("t1_frame_done", 32'(bus.frame_done), 1);
        check("t1_frame_valid", 32'(bus.frame_valid), 1);
        check("t1_frame_cnt", 32'(bus.frame_cnt), 1);
        check("t1_glyph_err", 32'(bus.glyph_err), 0);
        drive(12'd0, 14'd0);
        check("t1_done_pulse_end", 32'(bus.frame_done), 0);
        check_frame("t1", 0, -1, 0);
        read_addr(4'd12, "t1_rd12", 6'd37);
        check("t1_done_count", 32'(done_seen - base_done), 1);
        check("t1_serr_count", 32'(serr_seen - base_serr), 0);

        // Dwell 3 cycles per digit with blanking in between.
        base_done = done_seen;
        base_serr = serr_seen;
        sweep(0, 3, -1);
        drive(12'd0, 14'd0);
        check("t2_frame_cnt", 32'(bus.frame_cnt), 2);
        check_frame("t2", 0, -1, 0);
        check("t2_done_count", 32'(done_seen - base_done), 1);
        check("t2_serr_count", 32'(serr_seen - base_serr), 0);

        // Out-of-order digit: 0,1,2,4.
        pulse_reset();
        base_serr = serr_seen;
        drive_partial(0, 2);
        drive(12'd1 << 4, word_pat[0][4]);
        check("t3_seq_err", 32'(bus.seq_err), 1);
        check("t3_state", 32'(bus.state), 32'(HUNT));
        drive(12'd0, 14'd0);
        check("t3_seq_err_end", 32'(bus.seq_err), 0);
        check("t3_frame_valid", 32'(bus.frame_valid), 0);
        sweep(0, 1, -1);
        check("t3_frame_cnt", 32'(bus.frame_cnt), 1);
        check_frame("t3", 0, -1, 0);
        check("t3_serr_count", 32'(serr_seen - base_serr), 1);

        // Multi-hot select while capturing.
        pulse_reset();
        drive_partial(0, 1);
        drive(12'b000000000011, word_pat[0][2]);
        check("t4_seq_err", 32'(bus.seq_err), 1);
        check("t4_state", 32'(bus.state), 32'(HUNT));
        check("t4_frame_valid", 32'(bus.frame_valid), 0);
        check_frame("t4", 0, -1, 1);

        // Unknown glyph on digit 5, then a clean frame clears glyph_err.
        sweep(0, 1, 5);
        check("t5_frame_done", 32'(bus.frame_done), 1);
        check("t5_glyph_err", 32'(bus.glyph_err), 1);
        bus.rd_addr = 4'd5;
        drive(12'd0, 14'd0);
        check("t5_rd_in_done_cycle", 32'(bus.rd_data), 63);
        check_frame("t5", 0, 5, 0);
        sweep(0, 1, -1);
        check("t5_glyph_err_clear", 32'(bus.glyph_err), 0);

        // Collision / zero / N-tilde / space decode.
        sweep(1, 1, -1);
        check("t6_glyph_err", 32'(bus.glyph_err), 0);
        check_frame("t6", 1, -1, 0);

        // Reset mid-frame.
        drive_partial(0, 6);
        pulse_reset();
        check("t7_frame_valid", 32'(bus.frame_valid), 0);
        check("t7_frame_cnt", 32'(bus.frame_cnt), 0);
        check("t7_glyph_err", 32'(bus.glyph_err), 0);
        check("t7_rd_data", 32'(bus.rd_data), 0);
        check("t7_state", 32'(bus.state), 32'(HUNT));
        read_addr(4'd3, "t7_rd3", 6'd37);
        base_done = done_seen;
        drive_partial(7, 11);
        drive(12'd0, 14'd0);
        check("t7_no_done", 32'(done_seen - base_done), 0);
        check("t7_valid_still_0", 32'(bus.frame_valid), 0);
        sweep(0, 1, -1);
        check("t7_full_sweep_cnt", 32'(bus.frame_cnt), 1);

        // 256 back-to-back frames: counter wraps.
        pulse_reset();
        base_done = done_seen;
        for (int f = 0; f < 255; f++) sweep(f % 2, 1, -1);
        check("t8_cnt_255", 32'(bus.frame_cnt), 255);
        sweep(1, 1, -1);
        check("t8_cnt_wrap", 32'(bus.frame_cnt), 0);
        check("t8_valid_after_wrap", 32'(bus.frame_valid), 1);
        drive(12'd0, 14'd0);
        check("t8_done_count", 32'(done_seen - base_done), 256);
        check_frame("t8", 1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg14_scan_decoder.md
Name: seg14_scan_decoder

Overview:
- Receive-side counterpart of the 12-digit multiplexed 14-segment display driver.
- Snoops the one-hot digit select and the segment pattern, then decodes each glyph back to a 6-bit character code.
- Assembles complete 12-digit frames and exposes the last complete frame through a registered read port.
- Used as on-chip loopback checker and as the decode front end for the display capture path.

Parameters:
- N_DIGITS, 12, number of multiplexed digit positions; sel width; fixed 12 in this tapeout.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  12  one-hot digit select from the display driver; bit i means digit i.
- segm  in  14  segment pattern for the selected digit, MSB = segment a.
- rd_addr  in  4  frame-buffer read address, 0..11.
- rd_data  out  6  character code at rd_addr; registered.
- frame_valid  out  1  high once at least one complete frame has been latched.
- frame_done  out  1  one-cycle pulse when a new frame is latched.
- seq_err  out  1  one-cycle pulse on a select-sequence violation.
- glyph_err  out  1  high if the latched frame contains any unknown glyph.
- frame_cnt  out  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset:
  - rd_data=0; frame_valid, frame_done, seq_err, glyph_err=0; frame_cnt=0.
  - All shadow and output buffer entries = 37 (space).
  - State = HUNT.
  - Reset mid-frame discards the partial frame.
- Sampling: sel and segm are sampled every clk edge.
  - sel==0 is blanking: ignored; no state change, no error.
  - sel with more than one bit set is a violation.
  - Otherwise idx = position of the set bit.
- Decode is combinational from segm to code through the package glyph table:
  - digits '0'..'9' = 0..9; 'A'..'Z' = 10..35; Ñ = 36; space (all zeros) = 37; unmatched = 63.
  - Collision rule: pattern 10110111000000 (shared by S and 5) decodes to S (28).
  - Zero is the slashed pattern 11111100001001 only; 11111100000000 decodes to O (24).
- State machine, with exp = expected next index:
  - HUNT: idx==0 -> write shadow[0], set gerr_acc = (code==63), exp=1, go to CAPT. Any other idx is ignored silently.
  - CAPT, idx==exp: write shadow[idx], OR (code==63) into gerr_acc, exp++.
  - CAPT, idx==exp-1 (dwell on the same digit): rewrite shadow[idx] and recompute its error contribution only as an OR; no advance.
  - CAPT, idx==11 accepted: on the same edge the output buffer takes shadow with entry 11 replaced by the current code. In the next cycle frame_done=1, frame_valid=1, frame_cnt++ (wraps 255->0), and glyph_err = final gerr_acc. State returns to HUNT.
  - CAPT, any other idx or multi-hot sel: seq_err=1 next cycle; go to HUNT; shadow kept, output buffer untouched.
  - CAPT, multi-hot sel with idx==0 simultaneously: not possible, since multi-hot has priority as a violation.
  - HUNT, multi-hot sel: seq_err pulse; stay in HUNT.
- Frame boundary: a sample with idx==0 arriving in the cycle after idx==11 is accepted by HUNT normally. Back-to-back frames need no gap.
- Read port:
  - rd_data <= outbuf[rd_addr] every edge; 1-cycle latency.
  - rd_addr >= 12 returns 37.
  - A read addressed in the frame_done cycle returns the new frame.
- Width rules:
  - exp is 4 bits.
  - idx is encoded from 12-bit sel by priority-free OR encoding, valid only when one-hot.
  - One-hot check: sel!=0 and (sel & (sel-1))==0.

Decomposition:
- Package seg14_pkg holds:
  - character code constants: CH_0..CH_9, CH_A..CH_Z, CH_NN=36, CH_SPACE=37, CH_BAD=63;
  - 14-bit glyph pattern constants, identical to the driver's table;
  - state enum {HUNT, CAPT}.
- Sub-module seg14_glyph_decode: combinational segm[13:0] -> code[5:0] lookup. It is reusable by the driver-side self-check.

Test Plan:
- Driver-style sweep of "GALLEGOS0000", one cycle per digit, sel 1<<i -> frame_done one cycle after digit 11; rd 0..11 = 16,10,21,21,14,16,24,28,0,0,0,0; glyph_err=0; frame_cnt=1.
- Same sweep with each digit held 3 cycles and blanking sel=0 cycles inserted -> identical frame, exactly one frame_done, no seq_err.
- Digit order 0,1,2,4 -> seq_err pulse the cycle after digit 4. Then a clean sweep -> frame_cnt=1, and the buffer holds only the clean frame.
- sel=12'b000000000011 during CAPT -> seq_err pulse, return to HUNT, output buffer unchanged (reset default 37 at all addresses).
- Digit 5 segm=14'b00000000000001 (unknown) -> rd 5 = 63, glyph_err=1. Next clean frame -> glyph_err=0.
- Assert rst for one cycle after digit 6 -> all outputs reset; rd_addr=3 returns 37; no frame_done until a full new sweep. Additionally, run 256 frames -> frame_cnt wraps to 0 with frame_valid still 1.
